// File: rtl/uarch_pkg.sv
// Shared micro-architecture widths plus the instruction-cache geometry, state encoding
// and the address-field widths derived from that geometry.
package uarch_pkg;
    localparam int CPU_ADDR_BITS     = 32;
    localparam int CPU_INST_BITS     = 32;
    localparam int FETCH_WIDTH       = 2;

    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_NUM_LINES  = 64;
    localparam int ICACHE_OFF_BITS   = $clog2(ICACHE_LINE_WORDS * 4);
    localparam int ICACHE_IDX_BITS   = $clog2(ICACHE_NUM_LINES);
    localparam int ICACHE_TAG_BITS   = CPU_ADDR_BITS - ICACHE_OFF_BITS - ICACHE_IDX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MISS_REQ = 2'd1,
        REFILL   = 2'd2,
        REPLAY   = 2'd3
    } icache_state_t;
endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side request/response port and word-wide refill port of the instruction cache.
// The cache is the slave; fetch and the memory system together form the master view.
interface icache_dm_if;
    import uarch_pkg::*;

    logic [CPU_ADDR_BITS-1:0]             icache_addr;
    logic                                 icache_re;
    logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_dout;
    logic                                 icache_dout_val;
    logic                                 icache_stall;
    logic                                 flush;
    logic                                 invalidate;
    logic                                 mem_req_valid;
    logic                                 mem_req_ready;
    logic [CPU_ADDR_BITS-1:0]             mem_req_addr;
    logic                                 mem_resp_valid;
    logic [31:0]                          mem_resp_data;

    modport slave (
        input  icache_addr, icache_re, flush, invalidate,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        output icache_dout, icache_dout_val, icache_stall,
               mem_req_valid, mem_req_addr
    );

    modport master (
        output icache_addr, icache_re, flush, invalidate,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        input  icache_dout, icache_dout_val, icache_stall,
               mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/icache_data_array.sv
// Cache data RAM: one-word refill write port, registered-address read of an aligned
// FETCH_WIDTH-word group (data visible the cycle after rd_en; no backpressure).
module icache_data_array
    import uarch_pkg::*;
#(
    parameter  int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter  int NUM_LINES  = ICACHE_NUM_LINES,
    localparam int IDX_W      = $clog2(NUM_LINES),
    localparam int CNT_W      = $clog2(LINE_WORDS),
    localparam int NUM_GRP    = LINE_WORDS / FETCH_WIDTH,
    localparam int GRP_W      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1,
    localparam int AW         = IDX_W + CNT_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [IDX_W-1:0]                     wr_idx,
    input  logic [CNT_W-1:0]                     wr_word,
    input  logic [31:0]                          wr_data,
    input  logic                                 rd_en,
    input  logic [IDX_W-1:0]                     rd_idx,
    input  logic [GRP_W-1:0]                     rd_grp,
    output logic [FETCH_WIDTH*CPU_INST_BITS-1:0] rd_data
);
    logic [CPU_INST_BITS-1:0] mem [NUM_LINES*LINE_WORDS];
    logic [AW-1:0]            rd_base_q, rd_base_d;

    always_comb begin
        rd_base_d = rd_base_q;
        if (rd_en) begin
            rd_base_d = AW'(int'(rd_idx) * LINE_WORDS + int'(rd_grp) * FETCH_WIDTH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_base_q <= '0;
        else        rd_base_q <= rd_base_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_idx, wr_word}] <= wr_data;
    end

    // The read address is held across a refill, so the replay sees the freshly written line.
    always_comb begin
        rd_data = '0;
        for (int f = 0; f < FETCH_WIDTH; f++) begin
            rd_data[f*CPU_INST_BITS +: CPU_INST_BITS] = mem[rd_base_q + AW'(f)];
        end
    end
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only icache: hit data 1 cycle after accept; a miss refills one line
// word by word, holding icache_stall high from the miss lookup until the replay cycle.
module icache_dm
    import uarch_pkg::*;
#(
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
    input  logic       clk,
    input  logic       rst_n,
    icache_dm_if.slave bus
);
    localparam int OFF_W   = $clog2(LINE_WORDS * 4);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int TAG_W   = CPU_ADDR_BITS - OFF_W - IDX_W;
    localparam int CNT_W   = $clog2(LINE_WORDS);
    localparam int GRP_LSB = $clog2(FETCH_WIDTH * 4);
    localparam int NUM_GRP = LINE_WORDS / FETCH_WIDTH;
    localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

    icache_state_t            state_q, state_d;
    logic                     lookup_q, lookup_d;
    logic [TAG_W-1:0]         req_tag_q, req_tag_d;
    logic [IDX_W-1:0]         req_idx_q, req_idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     kill_q, kill_d;
    logic                     inv_q, inv_d;
    logic [NUM_LINES-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]         tag_ram [NUM_LINES];

    logic                     stall, dout_vld, req_vld, accept;
    logic                     data_we, tag_we, set_valid, hit;
    logic [CPU_ADDR_BITS-1:0] addr_sh;
    logic [GRP_W-1:0]         rd_grp;

    assign addr_sh = bus.icache_addr >> GRP_LSB;
    assign rd_grp  = GRP_W'(addr_sh) & GRP_W'(NUM_GRP - 1);
    assign hit     = lookup_q && valid_q[req_idx_q] && (tag_ram[req_idx_q] == req_tag_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kill_d    = kill_q;
        inv_d     = inv_q;
        valid_d   = valid_q;
        stall     = 1'b0;
        dout_vld  = 1'b0;
        req_vld   = 1'b0;
        data_we   = 1'b0;
        tag_we    = 1'b0;
        set_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (lookup_q && !bus.flush) begin
                    if (hit) begin
                        dout_vld = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                stall   = 1'b1;
                req_vld = 1'b1;
                if (bus.mem_req_ready) begin
                    state_d = REFILL;
                    cnt_d   = '0;
                end
            end
            REFILL: begin
                stall = 1'b1;
                if (bus.mem_resp_valid) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
                        tag_we    = 1'b1;
                        set_valid = !(inv_q || bus.invalidate);
                        state_d   = REPLAY;
                    end
                end
            end
            REPLAY: begin
                dout_vld = !kill_q && !bus.flush;
                state_d  = IDLE;
                kill_d   = 1'b0;
                inv_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // A redirect or fence mid-refill lets the refill finish but remembers to cancel it.
        if (state_q == MISS_REQ || state_q == REFILL) begin
            if (bus.flush)      kill_d = 1'b1;
            if (bus.invalidate) inv_d  = 1'b1;
        end

        if (bus.invalidate) valid_d = '0;
        else if (set_valid) valid_d[req_idx_q] = 1'b1;

        accept    = bus.icache_re && !stall;
        lookup_d  = accept;
        req_tag_d = accept ? bus.icache_addr[CPU_ADDR_BITS-1 -: TAG_W] : req_tag_q;
        req_idx_d = accept ? bus.icache_addr[OFF_W +: IDX_W]           : req_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lookup_q  <= 1'b0;
            req_tag_q <= '0;
            req_idx_q <= '0;
            cnt_q     <= '0;
            kill_q    <= 1'b0;
            inv_q     <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            lookup_q  <= lookup_d;
            req_tag_q <= req_tag_d;
            req_idx_q <= req_idx_d;
            cnt_q     <= cnt_d;
            kill_q    <= kill_d;
            inv_q     <= inv_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) tag_ram[req_idx_q] <= req_tag_q;
    end

    icache_data_array #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_data (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (data_we),
        .wr_idx  (req_idx_q),
        .wr_word (cnt_q),
        .wr_data (bus.mem_resp_data),
        .rd_en   (accept),
        .rd_idx  (bus.icache_addr[OFF_W +: IDX_W]),
        .rd_grp  (rd_grp),
        .rd_data (bus.icache_dout)
    );

    assign bus.icache_stall    = stall;
    assign bus.icache_dout_val = dout_vld;
    assign bus.mem_req_valid   = req_vld;
    assign bus.mem_req_addr    = req_vld ? {req_tag_q, req_idx_q, {OFF_W{1'b0}}} : '0;
endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed fetch sequences with expected groups queued on issue,
// a monitor popping them on icache_dout_val, and a responder modelling backing memory.
module tb_icache_dm;
    import uarch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        main_flush, resp_flush, main_inv, resp_inv;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    int          val_cnt = 0;
    int          last_pop_cyc = -1;
    int          ready_delay, flush_beat, inv_beat;
    logic [63:0] exp_q [$];
    logic [31:0] req_q [$];

    icache_dm_if bus ();
    assign bus.flush      = main_flush | resp_flush;
    assign bus.invalidate = main_inv | resp_inv;

    icache_dm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h3000: mem_word = 32'h11111111;
            32'h3004: mem_word = 32'h22222222;
            32'h3008: mem_word = 32'h33333333;
            32'h300C: mem_word = 32'h44444444;
            default:  mem_word = 32'hC0DE0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    // Monitor: every response must match the oldest outstanding expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.icache_stall) stall_cnt++;
                if (bus.icache_dout_val) begin
                    val_cnt++;
                    last_pop_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_dout: got %h, expected no response", bus.icache_dout);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dout", bus.icache_dout, e);
                    end
                end
            end
        end
    end

    // Backing memory: optional ready delay, then LINE_WORDS beats back to back.
    initial begin
        logic [31:0] a;
        int          dly, fb, ib;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        resp_flush         = 1'b0;
        resp_inv           = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && bus.mem_req_valid) begin
                a   = bus.mem_req_addr;
                dly = ready_delay;
                fb  = flush_beat;
                ib  = inv_beat;
                req_q.push_back(a);
                for (int i = 0; i < dly; i++) begin
                    chk("hold_req_valid", {63'd0, bus.mem_req_valid}, 64'd1);
                    chk("hold_req_addr", {32'd0, bus.mem_req_addr}, {32'd0, a});
                    chk("hold_stall", {63'd0, bus.icache_stall}, 64'd1);
                    chk("hold_no_dout", {63'd0, bus.icache_dout_val}, 64'd0);
                    @(posedge clk);
                    #1;
                end
                bus.mem_req_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.mem_req_ready = 1'b0;
                for (int b = 0; b < ICACHE_LINE_WORDS; b++) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = mem_word(a + 32'(4 * b));
                    resp_flush         = (b == fb);
                    resp_inv           = (b == ib);
                    @(posedge clk);
                    #1;
                end
                bus.mem_resp_valid = 1'b0;
                resp_flush         = 1'b0;
                resp_inv           = 1'b0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [63:0] e, input bit want, output int acc);
        bit st;
        int n;
        if (want) exp_q.push_back(e);
        bus.icache_addr = a;
        bus.icache_re   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            st = bus.icache_stall;
            @(posedge clk);
            #1;
            n++;
        end while (st && n < 300);
        bus.icache_re = 1'b0;
        acc = cyc;
        if (st) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: addr %h still stalled, expected acceptance", a);
        end
    endtask

    task automatic miss(input logic [31:0] a, input logic [63:0] e);
        int acc;
        issue(a, e, 1'b1, acc);
    endtask

    task automatic hit(input logic [31:0] a, input logic [63:0] e);
        int acc;
        issue(a, e, 1'b1, acc);
        @(negedge clk);
        #1;
        chk("hit_latency", 64'(last_pop_cyc), 64'(acc));
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input logic [31:0] a);
        int          n;
        logic [31:0] got;
        n = 0;
        while (req_q.size() == 0 && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (req_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL req_timeout: no refill seen, expected mem_req_addr %h", a);
        end else begin
            got = req_q.pop_front();
            chk("mem_req_addr", {32'd0, got}, {32'd0, a});
        end
    endtask

    initial begin
        int s0, v0, acc;
        int n;
        rst_n           = 1'b0;
        bus.icache_re   = 1'b0;
        bus.icache_addr = '0;
        main_flush      = 1'b0;
        main_inv        = 1'b0;
        ready_delay     = 0;
        flush_beat      = -1;
        inv_beat        = -1;

        repeat (3) @(negedge clk);
        chk("rst_dout_val", {63'd0, bus.icache_dout_val}, 64'd0);
        chk("rst_stall", {63'd0, bus.icache_stall}, 64'd0);
        chk("rst_req_valid", {63'd0, bus.mem_req_valid}, 64'd0);
        chk("rst_req_addr", {32'd0, bus.mem_req_addr}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss, then the other group of the same line hits straight out of replay.
        miss(32'h3000, 64'h22222222_11111111);
        hit(32'h3008, 64'h44444444_33333333);
        expect_req(32'h3000);
        chk("no_extra_req_cold", 64'(req_q.size()), 64'd0);

        // Four back-to-back hits: one group per cycle, stall never rises.
        s0 = stall_cnt;
        v0 = val_cnt;
        issue(32'h3000, 64'h22222222_11111111, 1'b1, acc);
        issue(32'h3008, 64'h44444444_33333333, 1'b1, acc);
        issue(32'h3000, 64'h22222222_11111111, 1'b1, acc);
        issue(32'h3008, 64'h44444444_33333333, 1'b1, acc);
        @(negedge clk);
        #1;
        chk("b2b_dout_count", 64'(val_cnt - v0), 64'd4);
        chk("b2b_stall_cycles", 64'(stall_cnt - s0), 64'd0);
        chk("b2b_last_latency", 64'(last_pop_cyc), 64'(acc));
        @(posedge clk);
        #1;

        // Conflict on index 0 with a slow memory handshake, then the evicted line misses.
        ready_delay = 5;
        miss(32'h3400, 64'hC0DE3404_C0DE3400);
        expect_req(32'h3400);
        ready_delay = 0;
        miss(32'h3000, 64'h22222222_11111111);
        expect_req(32'h3000);

        // Redirect during beat 2: no replay output, but the line is installed.
        flush_beat = 2;
        issue(32'hA000, 64'd0, 1'b0, acc);
        expect_req(32'hA000);
        flush_beat = -1;
        hit(32'hA004, 64'hC0DEA004_C0DEA000);
        chk("no_extra_req_flush", 64'(req_q.size()), 64'd0);

        // Fence mid-refill drops both the old line and the one being filled.
        miss(32'h3000, 64'h22222222_11111111);
        expect_req(32'h3000);
        hit(32'h3000, 64'h22222222_11111111);
        inv_beat = 1;
        miss(32'h5010, 64'hC0DE5014_C0DE5010);
        expect_req(32'h5010);
        inv_beat = -1;
        miss(32'h3000, 64'h22222222_11111111);
        expect_req(32'h3000);
        miss(32'h5010, 64'hC0DE5014_C0DE5010);
        expect_req(32'h5010);
        hit(32'h3000, 64'h22222222_11111111);

        // Fence while idle.
        main_inv = 1'b1;
        @(posedge clk);
        #1;
        main_inv = 1'b0;
        miss(32'h3000, 64'h22222222_11111111);
        expect_req(32'h3000);
        hit(32'h3008, 64'h44444444_33333333);

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pending_responses", 64'(exp_q.size()), 64'd0);
        chk("no_extra_req_end", 64'(req_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
